mult4_dot_accum: RTL and testbench
==================================

# mult4_dot_accum

Streaming dot-product stage built around the 4x4 unsigned array multiplier. It accepts 4-bit operand pairs over a valid/ready handshake and drives them into the combinational multiplier. It registers each 8-bit product and accumulates VEC_LEN consecutive products into one sum, which it presents on a valid/ready output port. The multiplier is a separate instance wired between mul_x/mul_y and mul_p; this block holds all the pipeline state around it.

## Interface

- VEC_LEN, default 4: products per dot product, >= 1.
- ACC_W, default 12: accumulator/result width. Must satisfy ACC_W >= 8 + clog2(VEC_LEN).
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous abort of the partially accumulated vector.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept an operand pair.
- in_x, input, 4: multiplicand, unsigned.
- in_y, input, 4: multiplier, unsigned.
- mul_x, output, 4: to multiplier x, driven from the operand register.
- mul_y, output, 4: to multiplier y, driven from the operand register.
- mul_p, input, 8: multiplier product o, combinational from mul_x/mul_y.
- out_valid, output, 1: out_sum holds a completed dot product.
- out_ready, input, 1: consumer accepts out_sum.
- out_sum, output, ACC_W: completed dot product.

## Operation

- Pipeline stages:
  - S1 operand register (op_x, op_y, op_v, op_last), which drives mul_x/mul_y.
  - S2 product register (prod, prod_v, prod_last), which captures mul_p.
  - S3 accumulator acc[ACC_W-1:0] and output register out_sum/out_valid.
- Element counter cnt, range 0..VEC_LEN-1:
  - Increments on each accepted pair (in_valid && in_ready).
  - The pair accepted when cnt == VEC_LEN-1 is tagged last, and cnt wraps to 0.
- stall = out_valid && !out_ready.
  - in_ready = !stall && !flush.
  - While stalled, S1, S2, acc and cnt hold their values.
- When not stalled, on each edge:
  - S1 loads the accepted pair, or clears op_v if no pair is accepted.
  - S2 loads from S1.
  - If prod_v && !prod_last: acc <= acc + prod.
  - If prod_v && prod_last: out_sum <= acc + prod, out_valid <= 1, acc <= 0.
- Output handshake:
  - out_valid && out_ready with no new result completing that cycle clears out_valid.
  - If a result completes in the same cycle, out_sum reloads and out_valid stays 1.
- flush (when not stalled, or while stalled):
  - Clears op_v, prod_v, acc and cnt.
  - Does not touch out_valid/out_sum.
  - Takes priority over acceptance, which is guaranteed because in_ready is low during flush.
- Arithmetic is unsigned and zero-extended into ACC_W. The sum is modulo 2^ACC_W; with a legal ACC_W it cannot overflow.
- out_sum is stable while out_valid && !out_ready.
- With VEC_LEN = 1, every pair is tagged last.

## Timing

- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_sum = 0.
  - mul_x = mul_y = 0.
  - cnt = 0, acc = 0, all stage valids = 0.
- Reset asserted mid-vector discards all partial state immediately (asynchronous).
- Latency: a last pair accepted at edge T gives out_valid = 1 after edge T+2. Products enter acc one per edge at T+2.
- Throughput: one pair per cycle with no stall. Back-to-back vectors need no bubble.
- Stall response: in_ready drops combinationally in the same cycle that out_valid && !out_ready holds. No accepted pair is ever lost or duplicated.
- flush and stall in the same cycle: flush still clears S1/S2/acc/cnt; the out register keeps holding.

## Test plan

- Basic vector, VEC_LEN=4, out_ready=1: pairs (1,15), (2,15), (3,15), (4,15) on consecutive cycles -> out_sum = 150, out_valid high for exactly one cycle, two cycles after the 4th accept.
- Max value and back-to-back: eight pairs of (15,15) streamed continuously -> two results of 900 on consecutive-vector boundaries, no in_ready drop.
- Backpressure: hold out_ready=0 while streaming two vectors (all pairs (2,3), sums 24) -> first result holds at 24; in_ready stays low until out_ready=1. The second sum is then 24, and no pair is lost.
- Flush: accept (5,5), (5,5), pulse flush, then send a fresh vector of four (1,1) -> out_sum = 4, not 54.
- Reset mid-vector: accept 2 pairs, assert rst_n=0 for one cycle -> all outputs return to reset values; the next full vector of (3,3) gives 36.
- Exhaustive, VEC_LEN=1: all 256 (x,y) pairs streamed -> each out_sum = x*y, in order, latency 2.

Source files
------------

// File: rtl/mult4_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : mult4_dot_accum
//  Description : Streaming dot-product stage around an external 4x4 unsigned
//                array multiplier. Operand pairs arrive over a valid/ready
//                handshake, are registered and presented to the multiplier.
//                Each product is registered and VEC_LEN consecutive products
//                are summed into one result, offered on a valid/ready port.
//                ACC_W must be at least 8 + clog2(VEC_LEN) so that a full
//                vector of maximum products cannot wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult4_dot_accum #(
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    output logic [3:0]       mul_x,
    output logic [3:0]       mul_y,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    // Element counter needs at least one bit even when VEC_LEN is 1.
    localparam int                c_cnt_w    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(VEC_LEN - 1);

    // S1 operand stage
    logic [3:0]         r_op_x;
    logic [3:0]         r_op_y;
    logic               r_op_v;
    logic               r_op_last;
    logic [c_cnt_w-1:0] r_cnt;

    // S2 product stage
    logic [7:0]         r_prod;
    logic               r_prod_v;
    logic               r_prod_last;

    // S3 accumulator and output register
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_valid;

    logic               w_stall;
    logic               w_accept;
    logic               w_cnt_last;
    logic               w_complete;
    logic [ACC_W-1:0]   w_sum;

    // A held result freezes the whole pipeline; flush also refuses input so
    // that abort always wins over a new pair.
    assign w_stall    = r_out_valid && !out_ready;
    assign in_ready   = !w_stall && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_last = (r_cnt == c_last_idx);
    assign w_sum      = r_acc + ACC_W'(r_prod);
    // A vector completes only when the pipeline advances and is not aborted.
    assign w_complete = !w_stall && !flush && r_prod_v && r_prod_last;

    assign mul_x     = r_op_x;
    assign mul_y     = r_op_y;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

    // S1: capture accepted operand pair, tag the last element, step the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_x    <= 4'd0;
            r_op_y    <= 4'd0;
            r_op_v    <= 1'b0;
            r_op_last <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_op_v    <= 1'b0;
            r_cnt     <= '0;
        end else if (!w_stall) begin
            r_op_v <= w_accept;
            if (w_accept) begin
                r_op_x    <= in_x;
                r_op_y    <= in_y;
                r_op_last <= w_cnt_last;
                r_cnt     <= w_cnt_last ? '0 : r_cnt + c_cnt_w'(1);
            end
        end
    end

    // S2: register the multiplier product alongside its valid/last tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod      <= 8'd0;
            r_prod_v    <= 1'b0;
            r_prod_last <= 1'b0;
        end else if (flush) begin
            r_prod_v    <= 1'b0;
        end else if (!w_stall) begin
            r_prod      <= mul_p;
            r_prod_v    <= r_op_v;
            r_prod_last <= r_op_last;
        end
    end

    // S3: running sum; restarts from zero once the last product is folded in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (flush) begin
            r_acc <= '0;
        end else if (!w_stall && r_prod_v) begin
            r_acc <= r_prod_last ? '0 : w_sum;
        end
    end

    // Output register: load a completed sum, otherwise drop valid on handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            r_out_sum   <= w_sum;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult4_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult4_dot_accum
//  Description : Self-checking bench for mult4_dot_accum. Instance A uses
//                VEC_LEN=4/ACC_W=12, instance B uses VEC_LEN=1/ACC_W=8. Each
//                external multiplier is modelled as a combinational product.
//                Expected sums are queued when stimulus is accepted and
//                popped when a result is handed off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult4_dot_accum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]  a_in_x, a_in_y, a_mul_x, a_mul_y;
    logic [7:0]  a_mul_p;
    logic [11:0] a_out_sum;
    assign a_mul_p = 8'(a_mul_x) * 8'(a_mul_y);

    // Instance B
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_in_x, b_in_y, b_mul_x, b_mul_y;
    logic [7:0]  b_mul_p;
    logic [7:0]  b_out_sum;
    assign b_mul_p = 8'(b_mul_x) * 8'(b_mul_y);

    mult4_dot_accum #(.VEC_LEN(4), .ACC_W(12)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_in_x), .in_y(a_in_y),
        .mul_x(a_mul_x), .mul_y(a_mul_y), .mul_p(a_mul_p),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum)
    );

    mult4_dot_accum #(.VEC_LEN(1), .ACC_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y),
        .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_p(b_mul_p),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] qa[$];
    logic [7:0]  qb[$];

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_out_sum !== 12'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", a_out_sum); end
        n_checks++; if (a_mul_x !== 4'd0 || a_mul_y !== 4'd0) begin n_fail++; $display("FAIL reset_mul: got %0d,%0d want 0,0", a_mul_x, a_mul_y); end
        n_checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b: got valid %b ready %b want 0 1", b_out_valid, b_in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [11:0] s;
        logic [11:0] exp_v;
        s = 12'd0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_x = 4'(i + 1); a_in_y = 4'd15;
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", a_in_ready); end
            s = s + {8'd0, a_in_x} * {8'd0, a_in_y};
        end
        qa.push_back(s);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            n_checks++; if (a_out_valid !== (k == 2)) begin n_fail++; $display("FAIL basic_latency: cycle %0d got valid %b want %b", k, a_out_valid, (k == 2)); end
            if (a_out_valid) begin
                n_checks++;
                if (qa.size() == 0) begin n_fail++; $display("FAIL basic_sum: got %0d, none expected", a_out_sum); end
                else begin exp_v = qa.pop_front(); if (a_out_sum !== exp_v) begin n_fail++; $display("FAIL basic_sum: got %0d want %0d", a_out_sum, exp_v); end end
            end
        end
        n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d pending want 0", qa.size()); qa.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_v;
        a_out_ready = 1'b1;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            a_in_valid = (j < 8); a_in_x = 4'd15; a_in_y = 4'd15;
            #1;
            if (j < 8) begin
                n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", j, a_in_ready); end
                if (j == 3 || j == 7) qa.push_back(12'd900);
            end
            n_checks++; if (a_out_valid !== (j == 6 || j == 10)) begin n_fail++; $display("FAIL b2b_valid: cycle %0d got %b want %b", j, a_out_valid, (j == 6 || j == 10)); end
            if (a_out_valid) begin
                n_checks++;
                if (qa.size() == 0) begin n_fail++; $display("FAIL b2b_sum: got %0d, none expected", a_out_sum); end
                else begin exp_v = qa.pop_front(); if (a_out_sum !== exp_v) begin n_fail++; $display("FAIL b2b_sum: got %0d want %0d", a_out_sum, exp_v); end end
            end
        end
        n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", qa.size()); qa.delete(); end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_v;
        int accepted;
        a_out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_x = 4'd2; a_in_y = 4'd3;
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready: cycle %0d got %b want 1", j, a_in_ready); end
            if (j == 3) qa.push_back(12'd24);
        end
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            #1;
            n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", h, a_out_valid); end
            n_checks++; if (a_out_sum !== 12'd24) begin n_fail++; $display("FAIL bp_hold_sum: cycle %0d got %0d want 24", h, a_out_sum); end
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: cycle %0d got %b want 0", h, a_in_ready); end
        end
        accepted = 6;
        for (int c = 0; c < 20 && (accepted < 8 || qa.size() > 0); c++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            a_in_valid = (accepted < 8);
            #1;
            if (a_out_valid) begin
                n_checks++;
                if (qa.size() == 0) begin n_fail++; $display("FAIL bp_sum: got %0d, none expected", a_out_sum); end
                else begin exp_v = qa.pop_front(); if (a_out_sum !== exp_v) begin n_fail++; $display("FAIL bp_sum: got %0d want %0d", a_out_sum, exp_v); end end
            end
            if (a_in_valid && a_in_ready) begin
                accepted++;
                if (accepted == 8) qa.push_back(12'd24);
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        n_checks++; if (accepted != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", accepted); end
        n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending want 0", qa.size()); qa.delete(); end
    endtask

    task automatic test_flush();
        logic [11:0] exp_v;
        a_out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_x = 4'd5; a_in_y = 4'd5;
        end
        @(negedge clk);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_x = 4'd9; a_in_y = 4'd9;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", a_in_ready); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a_flush = 1'b0; a_in_valid = 1'b1; a_in_x = 4'd1; a_in_y = 4'd1;
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", a_in_ready); end
        end
        qa.push_back(12'd4);
        for (int c = 0; c < 10 && qa.size() > 0; c++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            if (a_out_valid) begin
                n_checks++;
                exp_v = qa.pop_front();
                if (a_out_sum !== exp_v) begin n_fail++; $display("FAIL flush_sum: got %0d want %0d", a_out_sum, exp_v); end
            end
        end
        n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending want 0", qa.size()); qa.delete(); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp_v;
        a_out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_x = 4'd7; a_in_y = 4'd7;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags: got valid %b ready %b want 0 1", a_out_valid, a_in_ready); end
        n_checks++; if (a_out_sum !== 12'd0) begin n_fail++; $display("FAIL rstmid_sum: got %0d want 0", a_out_sum); end
        n_checks++; if (a_mul_x !== 4'd0 || a_mul_y !== 4'd0) begin n_fail++; $display("FAIL rstmid_mul: got %0d,%0d want 0,0", a_mul_x, a_mul_y); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_x = 4'd3; a_in_y = 4'd3;
        end
        qa.push_back(12'd36);
        for (int c = 0; c < 10 && qa.size() > 0; c++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            if (a_out_valid) begin
                n_checks++;
                exp_v = qa.pop_front();
                if (a_out_sum !== exp_v) begin n_fail++; $display("FAIL rstmid_result: got %0d want %0d", a_out_sum, exp_v); end
            end
        end
        n_checks++; if (qa.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d pending want 0", qa.size()); qa.delete(); end
    endtask

    task automatic test_exhaustive();
        logic [7:0] jv;
        logic [7:0] exp_v;
        logic       exp_valid;
        b_out_ready = 1'b1;
        for (int j = 0; j < 260; j++) begin
            @(negedge clk);
            if (j < 256) begin
                jv = 8'(j);
                b_in_valid = 1'b1; b_in_x = jv[7:4]; b_in_y = jv[3:0];
                qb.push_back(8'(b_in_x) * 8'(b_in_y));
            end else begin
                b_in_valid = 1'b0;
            end
            #1;
            exp_valid = (j >= 3 && j <= 258);
            n_checks++; if (b_out_valid !== exp_valid) begin n_fail++; $display("FAIL exh_valid: cycle %0d got %b want %b", j, b_out_valid, exp_valid); end
            if (b_out_valid) begin
                n_checks++;
                if (qb.size() == 0) begin n_fail++; $display("FAIL exh_sum: got %0d, none expected", b_out_sum); end
                else begin exp_v = qb.pop_front(); if (b_out_sum !== exp_v) begin n_fail++; $display("FAIL exh_sum: cycle %0d got %0d want %0d", j, b_out_sum, exp_v); end end
            end
        end
        n_checks++; if (qb.size() != 0) begin n_fail++; $display("FAIL exh_drain: got %0d pending want 0", qb.size()); qb.delete(); end
    endtask

    initial begin
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_x = 4'd0; a_in_y = 4'd0; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_x = 4'd0; b_in_y = 4'd0; b_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
